axi2tlul: RTL and testbench

AXI2TLUL -- requirements
Module: axi2tlul

---
 rtl/tlul2axi_pkg.sv | 77 +++++++
 rtl/tlul_pkg.sv | 30 +++
 rtl/axi2tlul_addr_gen.sv | 31 +++
 rtl/axi2tlul.sv | 219 +++++++++++++++++++++
 tb/tb_axi2tlul.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul2axi_pkg.sv
// Shared types for the AXI4 subordinate to TL-UL host bridge: AXI channel
// structs, bridge FSM state enum, response codes and the check for burst
// shapes the bridge cannot translate.
package tlul2axi_pkg;

    localparam int unsigned AXI_ID_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        WR_B
    } axi2tlul_state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [31:0]             addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [1:0]              resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [31:0]             data;
        logic [1:0]              resp;
        logic                    last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } slv_rsp_t;

    // WRAP (and the reserved burst encoding) or beats wider than 32 bits
    // cannot be mapped onto TL-UL and are answered locally with SLVERR.
    function automatic logic unsupported(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'd2);
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL types used by the AXI-to-TL-UL bridge.
//   tl_h2d_t : host-to-device A channel plus d_ready
//   tl_d2h_t : device-to-host D channel plus a_ready
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/axi2tlul_addr_gen.sv
// Beat address helper for axi2tlul.
//   addr         : current beat address
//   size, burst  : captured AXI size / burst type
//   next_addr    : address of the following beat (FIXED holds, INCR steps)
//   aligned_addr : current address aligned down to the beat size
//   get_mask     : byte lanes of a Get for this size and address
module axi2tlul_addr_gen
    import tlul2axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic [31:0] aligned_addr,
    output logic [3:0]  get_mask
);

    logic [31:0] step;

    always_comb begin
        step         = 32'd1 << size;
        next_addr    = (burst == BURST_FIXED) ? addr : addr + step;
        aligned_addr = addr & ~(step - 32'd1);
        case (size)
            3'd0:    get_mask = 4'b0001 << addr[1:0];
            3'd1:    get_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: get_mask = 4'b1111;
        endcase
    end

endmodule

// File: rtl/axi2tlul.sv
// AXI4 subordinate to TL-UL host bridge, one transaction at a time.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   axi_req_i     : AXI AW/W/B-ready/AR/R-ready from the manager
//   axi_rsp_o     : AXI ready/B/R back to the manager
//   tl_o          : TL-UL A channel and d_ready
//   tl_i          : TL-UL D channel and a_ready
// Macro AXI2TLUL_RD_PRIO_EN: when defined AR always beats a simultaneous AW;
// otherwise a round-robin pointer (reset favours reads) decides.
module axi2tlul #(
    parameter int unsigned AXI_ID_WIDTH = tlul2axi_pkg::AXI_ID_WIDTH,
    parameter type axi_req_t = tlul2axi_pkg::slv_req_t,
    parameter type axi_rsp_t = tlul2axi_pkg::slv_rsp_t
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  axi_req_t          axi_req_i,
    output axi_rsp_t          axi_rsp_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i
);
    import tlul2axi_pkg::*;

    axi2tlul_state_e         state;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [31:0]             addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    bad_q;
    logic                    err_q;
    logic                    rr_q;

    logic        grant_rd;
    logic        grant_wr;
    logic        r_fire;
    logic        w_fire;
    logic        last_beat;
    logic [31:0] next_addr;
    logic [31:0] aligned_addr;
    logic [3:0]  get_mask;
    logic        unused_wlast;

    // Beat count is tracked internally; wlast carries no extra information.
    assign unused_wlast = axi_req_i.w.last;
    assign last_beat    = (cnt_q == len_q);

    axi2tlul_addr_gen u_addr_gen (
        .addr         (addr_q),
        .size         (size_q),
        .burst        (burst_q),
        .next_addr    (next_addr),
        .aligned_addr (aligned_addr),
        .get_mask     (get_mask)
    );

    // Only one of ar_ready/aw_ready is ever raised; gated by rst_ni so no
    // handshake can be offered while reset is held.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE && rst_ni) begin
`ifdef AXI2TLUL_RD_PRIO_EN
            grant_rd = axi_req_i.ar_valid;
`else
            grant_rd = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !rr_q);
`endif
            grant_wr = axi_req_i.aw_valid && !grant_rd;
        end
    end

`ifdef AXI2TLUL_RD_PRIO_EN
    logic unused_rr;
    assign unused_rr = rr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        id_q    <= axi_req_i.ar.id;
                        addr_q  <= axi_req_i.ar.addr;
                        len_q   <= axi_req_i.ar.len;
                        size_q  <= axi_req_i.ar.size;
                        burst_q <= axi_req_i.ar.burst;
                        bad_q   <= unsupported(axi_req_i.ar.burst, axi_req_i.ar.size);
                        cnt_q   <= '0;
                        rr_q    <= ~rr_q;
                        state   <= unsupported(axi_req_i.ar.burst, axi_req_i.ar.size) ? RD_RSP : RD_REQ;
                    end else if (grant_wr) begin
                        id_q    <= axi_req_i.aw.id;
                        addr_q  <= axi_req_i.aw.addr;
                        len_q   <= axi_req_i.aw.len;
                        size_q  <= axi_req_i.aw.size;
                        burst_q <= axi_req_i.aw.burst;
                        bad_q   <= unsupported(axi_req_i.aw.burst, axi_req_i.aw.size);
                        err_q   <= unsupported(axi_req_i.aw.burst, axi_req_i.aw.size);
                        cnt_q   <= '0;
                        rr_q    <= ~rr_q;
                        state   <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (tl_i.a_ready) state <= RD_RSP;
                end
                RD_RSP: begin
                    if (r_fire) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= next_addr;
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= bad_q ? RD_RSP : RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // Unsupported writes drain W locally without touching TL-UL.
                    if (w_fire) begin
                        if (!bad_q) begin
                            state <= WR_RSP;
                        end else if (last_beat) begin
                            state <= WR_B;
                        end else begin
                            addr_q <= next_addr;
                            cnt_q  <= cnt_q + 8'd1;
                        end
                    end
                end
                WR_RSP: begin
                    if (tl_i.d_valid) begin
                        err_q <= err_q | tl_i.d_error;
                        if (last_beat) begin
                            state <= WR_B;
                        end else begin
                            addr_q <= next_addr;
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= WR_REQ;
                        end
                    end
                end
                WR_B: begin
                    if (axi_req_i.b_ready) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        axi_rsp_o          = '0;
        tl_o               = '0;
        r_fire             = 1'b0;
        w_fire             = 1'b0;
        axi_rsp_o.ar_ready = grant_rd;
        axi_rsp_o.aw_ready = grant_wr;
        axi_rsp_o.r.id     = id_q;
        axi_rsp_o.r.last   = last_beat;
        axi_rsp_o.b.id     = id_q;
        tl_o.a_opcode      = tlul_pkg::Get;
        tl_o.a_address     = aligned_addr;
        case (state)
            RD_REQ: begin
                tl_o.a_valid = 1'b1;
                tl_o.a_size  = size_q[1:0];
                tl_o.a_mask  = get_mask;
            end
            RD_RSP: begin
                if (bad_q) begin
                    axi_rsp_o.r_valid = 1'b1;
                    axi_rsp_o.r.resp  = RESP_SLVERR;
                end else begin
                    axi_rsp_o.r_valid = tl_i.d_valid;
                    tl_o.d_ready      = axi_req_i.r_ready;
                    axi_rsp_o.r.data  = tl_i.d_data;
                    axi_rsp_o.r.resp  = tl_i.d_error ? RESP_SLVERR : RESP_OKAY;
                end
                r_fire = axi_rsp_o.r_valid && axi_req_i.r_ready;
            end
            WR_REQ: begin
                if (bad_q) begin
                    axi_rsp_o.w_ready = 1'b1;
                end else begin
                    tl_o.a_valid      = axi_req_i.w_valid;
                    axi_rsp_o.w_ready = tl_i.a_ready;
                    tl_o.a_opcode     = (axi_req_i.w.strb == 4'hF && size_q == 3'd2) ?
                                        tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
                    tl_o.a_size       = 2'd2;
                    tl_o.a_mask       = axi_req_i.w.strb;
                    tl_o.a_data       = axi_req_i.w.data;
                    tl_o.a_address    = {addr_q[31:2], 2'b00};
                end
                w_fire = axi_req_i.w_valid && axi_rsp_o.w_ready;
            end
            WR_RSP: tl_o.d_ready = 1'b1;
            WR_B: begin
                axi_rsp_o.b_valid = 1'b1;
                axi_rsp_o.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi2tlul.sv
module tb_axi2tlul;

    logic clk;
    logic rst_ni;
    tlul2axi_pkg::slv_req_t req;
    tlul2axi_pkg::slv_rsp_t rsp;
    tlul_pkg::tl_h2d_t      tl_h2d;
    tlul_pkg::tl_d2h_t      tl_d2h;

    int checks;
    int failures;

    axi2tlul dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .axi_req_i (req),
        .axi_rsp_o (rsp),
        .tl_o      (tl_h2d),
        .tl_i      (tl_d2h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [3:0]  derr;
        logic        bad;
        logic [3:0]  mask;
        logic [2:0]  op;
        logic [1:0]  bresp;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req    = '0;
        tl_d2h = '0;
    endtask

    task automatic do_vec(input vec_t v);
        logic [31:0] ea;
        logic [31:0] step;
        logic [31:0] dat;
        int n;
        step = 32'd1 << v.size;
        if (v.is_wr) begin
            req.aw.id = v.id; req.aw.addr = v.addr; req.aw.len = v.len;
            req.aw.size = v.size; req.aw.burst = v.burst; req.aw_valid = 1'b1;
        end else begin
            req.ar.id = v.id; req.ar.addr = v.addr; req.ar.len = v.len;
            req.ar.size = v.size; req.ar.burst = v.burst; req.ar_valid = 1'b1;
        end
        n = 0;
        #1;
        while (!(v.is_wr ? rsp.aw_ready : rsp.ar_ready) && n < 20) begin
            tick(); #1; n++;
        end
        chk("ax_ready", 32'(v.is_wr ? rsp.aw_ready : rsp.ar_ready), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            ea = (v.burst == 2'd0) ? v.addr : v.addr + step * 32'(b);
            if (!v.is_wr) begin
                if (!v.bad) begin
                    tl_d2h.a_ready = 1'b1;
                    #1;
                    chk("rd_a_valid", 32'(tl_h2d.a_valid), 32'd1);
                    chk("rd_a_opcode", 32'(tl_h2d.a_opcode), 32'd4);
                    chk("rd_a_address", tl_h2d.a_address, ea);
                    chk("rd_a_source", 32'(tl_h2d.a_source), 32'd0);
                    if (b == 0) begin
                        chk("rd_a_mask", 32'(tl_h2d.a_mask), 32'(v.mask));
                        chk("rd_a_size", 32'(tl_h2d.a_size), 32'(v.size));
                    end
                    tick();
                    tl_d2h.a_ready = 1'b0;
                end
                dat = 32'hD000_0000 ^ ea;
                tl_d2h.d_valid = !v.bad;
                tl_d2h.d_data  = dat;
                tl_d2h.d_error = v.derr[2'(b)];
                req.r_ready    = 1'b1;
                #1;
                chk("r_valid", 32'(rsp.r_valid), 32'd1);
                chk("r_data", rsp.r.data, v.bad ? 32'd0 : dat);
                chk("r_resp", 32'(rsp.r.resp), (v.bad || v.derr[2'(b)]) ? 32'd2 : 32'd0);
                chk("r_last", 32'(rsp.r.last), 32'(8'(b) == v.len));
                chk("r_id", 32'(rsp.r.id), 32'(v.id));
                if (v.bad) chk("bad_rd_no_a_valid", 32'(tl_h2d.a_valid), 32'd0);
                tick();
                tl_d2h.d_valid = 1'b0;
                tl_d2h.d_error = 1'b0;
                req.r_ready    = 1'b0;
            end else begin
                dat = 32'h5A00_0000 + 32'(b) * 32'h0101;
                req.w.data  = dat;
                req.w.strb  = v.strb;
                req.w.last  = (8'(b) == v.len);
                req.w_valid = 1'b1;
                tl_d2h.a_ready = 1'b1;
                #1;
                chk("w_ready", 32'(rsp.w_ready), 32'd1);
                chk("wr_a_valid", 32'(tl_h2d.a_valid), 32'(!v.bad));
                if (!v.bad) begin
                    chk("wr_a_opcode", 32'(tl_h2d.a_opcode), 32'(v.op));
                    chk("wr_a_mask", 32'(tl_h2d.a_mask), 32'(v.mask));
                    chk("wr_a_data", tl_h2d.a_data, dat);
                    chk("wr_a_address", tl_h2d.a_address, ea & ~32'd3);
                    chk("wr_a_size", 32'(tl_h2d.a_size), 32'd2);
                end
                tick();
                req.w_valid = 1'b0;
                tl_d2h.a_ready = 1'b0;
                if (!v.bad) begin
                    tl_d2h.d_valid = 1'b1;
                    tl_d2h.d_error = v.derr[2'(b)];
                    #1;
                    chk("wr_d_ready", 32'(tl_h2d.d_ready), 32'd1);
                    tick();
                    tl_d2h.d_valid = 1'b0;
                    tl_d2h.d_error = 1'b0;
                end
            end
        end
        if (v.is_wr) begin
            req.b_ready = 1'b1;
            #1;
            chk("b_valid", 32'(rsp.b_valid), 32'd1);
            chk("b_resp", 32'(rsp.b.resp), 32'(v.bresp));
            chk("b_id", 32'(rsp.b.id), 32'(v.id));
            tick();
            req.b_ready = 1'b0;
        end
        #1;
        chk("quiet_after", 32'({rsp.r_valid, rsp.b_valid, tl_h2d.a_valid}), 32'd0);
    endtask

    initial begin
        //            wr    id     addr        len   size  burst strb   derr     bad   mask   op    bresp
        vecs[0] = '{1'b0, 4'd1, 32'h100, 8'd3, 3'd2, 2'd1, 4'h0, 4'b0000, 1'b0, 4'hF, 3'd4, 2'd0};
        vecs[1] = '{1'b1, 4'd2, 32'h020, 8'd0, 3'd2, 2'd1, 4'h3, 4'b0001, 1'b0, 4'h3, 3'd1, 2'd2};
        vecs[2] = '{1'b1, 4'd3, 32'h040, 8'd1, 3'd2, 2'd1, 4'hF, 4'b0000, 1'b0, 4'hF, 3'd0, 2'd0};
        vecs[3] = '{1'b0, 4'd4, 32'h202, 8'd0, 3'd0, 2'd1, 4'h0, 4'b0001, 1'b0, 4'h4, 3'd4, 2'd0};
        vecs[4] = '{1'b0, 4'd5, 32'h300, 8'd1, 3'd2, 2'd2, 4'h0, 4'b0000, 1'b1, 4'h0, 3'd4, 2'd0};
        vecs[5] = '{1'b1, 4'd6, 32'h400, 8'd2, 3'd3, 2'd1, 4'hF, 4'b0000, 1'b1, 4'hF, 3'd0, 2'd2};
        vecs[6] = '{1'b0, 4'd7, 32'h050, 8'd2, 3'd2, 2'd0, 4'h0, 4'b0010, 1'b0, 4'hF, 3'd4, 2'd0};
        vecs[7] = '{1'b0, 4'd8, 32'h012, 8'd0, 3'd1, 2'd1, 4'h0, 4'b0000, 1'b0, 4'hC, 3'd4, 2'd0};
        vecs[8] = '{1'b1, 4'd9, 32'h060, 8'd1, 3'd2, 2'd1, 4'hF, 4'b0001, 1'b0, 4'hF, 3'd0, 2'd2};
        vecs[9] = '{1'b1, 4'hA, 32'h070, 8'd0, 3'd0, 2'd1, 4'hF, 4'b0000, 1'b0, 4'hF, 3'd1, 2'd0};

        checks   = 0;
        failures = 0;
        clear_inputs();
        rst_ni = 1'b0;
        req.ar_valid = 1'b1;
        req.aw_valid = 1'b1;
        tick(); tick();
        #1;
        chk("rst_ar_ready", 32'(rsp.ar_ready), 32'd0);
        chk("rst_aw_ready", 32'(rsp.aw_ready), 32'd0);
        chk("rst_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        chk("rst_rb_valid", 32'({rsp.r_valid, rsp.b_valid}), 32'd0);
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) do_vec(vecs[i]);

        // R back-pressure: D must be held off while r_ready is low
        tick();
        req.ar.id = 4'd2; req.ar.addr = 32'h80; req.ar.len = 8'd0;
        req.ar.size = 3'd2; req.ar.burst = 2'd1; req.ar_valid = 1'b1;
        #1;
        chk("bp_ar_ready", 32'(rsp.ar_ready), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        tl_d2h.a_ready = 1'b1;
        tick();
        tl_d2h.a_ready = 1'b0;
        tl_d2h.d_valid = 1'b1;
        tl_d2h.d_data  = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_r_valid", 32'(rsp.r_valid), 32'd1);
            chk("bp_d_ready", 32'(tl_h2d.d_ready), 32'd0);
            chk("bp_r_data", rsp.r.data, 32'hCAFE_F00D);
            tick();
        end
        req.r_ready = 1'b1;
        #1;
        chk("bp_d_ready_rel", 32'(tl_h2d.d_ready), 32'd1);
        tick();
        clear_inputs();

        // Reset during the second beat of a 4-beat write
        req.aw.id = 4'hB; req.aw.addr = 32'h500; req.aw.len = 8'd3;
        req.aw.size = 3'd2; req.aw.burst = 2'd1; req.aw_valid = 1'b1;
        #1;
        chk("mr_aw_ready", 32'(rsp.aw_ready), 32'd1);
        tick();
        req.aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            req.w.data = 32'h1234_0000 + 32'(b); req.w.strb = 4'hF; req.w_valid = 1'b1;
            tl_d2h.a_ready = 1'b1;
            tick();
            req.w_valid = 1'b0;
            tl_d2h.a_ready = 1'b0;
            if (b == 0) begin
                tl_d2h.d_valid = 1'b1;
                tick();
                tl_d2h.d_valid = 1'b0;
            end
        end
        rst_ni = 1'b0;
        req.ar_valid = 1'b1; req.aw_valid = 1'b1; req.w_valid = 1'b1;
        req.b_ready = 1'b1; req.r_ready = 1'b1; tl_d2h.d_valid = 1'b1;
        #1;
        chk("mr_a_valid", 32'(tl_h2d.a_valid), 32'd0);
        chk("mr_d_ready", 32'(tl_h2d.d_ready), 32'd0);
        chk("mr_readies", 32'({rsp.ar_ready, rsp.aw_ready, rsp.w_ready}), 32'd0);
        chk("mr_rb_valid", 32'({rsp.r_valid, rsp.b_valid}), 32'd0);
        tick();
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        req.b_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("mr_no_b_valid", 32'(rsp.b_valid), 32'd0);
            tick();
        end
        req.b_ready = 1'b0;
        do_vec(vecs[2]);

        // Simultaneous AR/AW arbitration, starting from a fresh pointer
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        req.ar.id = 4'd1; req.ar.addr = 32'h600; req.ar.len = 8'd0;
        req.ar.size = 3'd2; req.ar.burst = 2'd1; req.ar_valid = 1'b1;
        req.aw.id = 4'd2; req.aw.addr = 32'h700; req.aw.len = 8'd0;
        req.aw.size = 3'd2; req.aw.burst = 2'd1; req.aw_valid = 1'b1;
        #1;
        chk("arb1_ar_ready", 32'(rsp.ar_ready), 32'd1);
        chk("arb1_aw_ready", 32'(rsp.aw_ready), 32'd0);
        tick();
        req.ar_valid = 1'b0;
        tl_d2h.a_ready = 1'b1;
        #1;
        chk("arb_busy_aw_ready", 32'(rsp.aw_ready), 32'd0);
        tick();
        tl_d2h.a_ready = 1'b0;
        tl_d2h.d_valid = 1'b1;
        req.r_ready = 1'b1;
        tick();
        tl_d2h.d_valid = 1'b0;
        req.r_ready = 1'b0;
        req.ar_valid = 1'b1;
        #1;
`ifdef AXI2TLUL_RD_PRIO_EN
        chk("arb2_ar_ready", 32'(rsp.ar_ready), 32'd1);
        chk("arb2_aw_ready", 32'(rsp.aw_ready), 32'd0);
`else
        chk("arb2_ar_ready", 32'(rsp.ar_ready), 32'd0);
        chk("arb2_aw_ready", 32'(rsp.aw_ready), 32'd1);
`endif
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
